ball_motion_master: RTL and testbench
=====================================

// Module: ball_motion_master
// PURPOSE
//  Avalon-MM write initiator that animates the ball on the vga_ball peripheral. On each frame tick it
//  steps ball X/Y by a fixed velocity and bounces off the screen edges. It then issues byte writes to
//  the peripheral's position registers: addr 3=X[7:0], 4=X[10:8], 5=Y[7:0], 6=Y[9:8].
//  Sits between the frame-timing source (start of vertical blanking) and the vga_ball slave port.
// PARAMETERS
//  X_MIN    0    left screen edge, pixels
//  X_MAX    639  right screen edge, pixels
//  Y_MIN    0    top screen edge, pixels
//  Y_MAX    479  bottom screen edge, pixels
//  RADIUS   30   ball radius; centre limits are [X_MIN+RADIUS, X_MAX-RADIUS], same form for Y
//  VX       2    X step per frame, pixels (1..15)
//  VY       1    Y step per frame, pixels (1..15)
//  INIT_X   400  reset X centre (11 bit)
//  INIT_Y   300  reset Y centre (10 bit)
// PORTS
//  clk              in   1   system clock (50 MHz)
//  reset            in   1   asynchronous, active-high
//  frame_tick       in   1   1-cycle pulse, once per frame at start of vertical blanking
//  enable           in   1   1 = respond to frame_tick
//  avm_chipselect   out  1   Avalon chipselect, same value as avm_write
//  avm_write        out  1   Avalon write strobe
//  avm_address      out  3   register address
//  avm_writedata    out  8   write data
//  avm_waitrequest  in   1   slave stall; tie 0 for a zero-wait slave
//  busy             out  1   1 whenever state != IDLE
//  missed_frames    out  8   saturating count of frame_tick pulses dropped while busy
// BEHAVIOUR
//  Reset (async): state=IDLE; x=INIT_X, y=INIT_Y; dir_x=dir_y=+; avm_* = 0; busy=0; missed_frames=0.
//  States: IDLE -> UPDATE -> WR_XL -> WR_XH -> WR_YL -> WR_YH -> IDLE.
//  IDLE: if frame_tick && enable, go to UPDATE next cycle. If enable=0, frame_tick is ignored and not counted.
//  UPDATE (1 cycle): compute the new position (X shown; Y is the same with VY/Y_*).
//   +dir: if x+VX >= X_MAX-RADIUS then x=X_MAX-RADIUS and dir_x flips to -; else x=x+VX.
//   -dir: if x < X_MIN+RADIUS+VX then x=X_MIN+RADIUS and dir_x flips to +; else x=x-VX.
//   Compare at 12 bits so nothing wraps. X and Y are independent; a corner flips both in one frame.
//   The bounce flag is set if either axis flipped.
//  WR_* states: avm_write=avm_chipselect=1 with the address/data of that state.
//   Address and data stay stable while avm_waitrequest=1.
//   The state advances on the cycle where avm_write && !avm_waitrequest.
//   Write data: XL=x[7:0], XH={5'b0,x[10:8]}, YL=y[7:0], YH={6'b0,y[9:8]}.
//  Write order is fixed: X low, X high, Y low, Y high.
//  Latency with zero wait states: tick in cycle T; UPDATE in T+1; writes in T+2..T+5; IDLE at T+6.
//  frame_tick while busy: the pulse is dropped, the in-flight sequence is unaffected, and missed_frames
//   increments, saturating at 255. A tick in the same cycle the FSM returns to IDLE is counted as missed.
//  enable falling mid-sequence: the sequence completes; no new tick is accepted.
//  Reset mid-sequence: avm_write/chipselect drop immediately and position returns to INIT.
//   A partial write sequence is acceptable because vga_ball latches position only at blanking.
// CONFIGURATION
//  BALL_BOUNCE_COLOR_EN defined: 3-bit color_idx (reset 0) increments on each bounce frame, wrapping 7->0.
//   On a bounce frame, states WR_R, WR_G, WR_B follow WR_YH and write addr 0,1,2 with the new index.
//   Data: R=idx[0]?FF:00, G=idx[1]?FF:00, B=idx[2]?FF:00.
//   Non-bounce frames produce 4 writes only.
//  BALL_BOUNCE_COLOR_EN undefined: no color logic, no color states, and addr 0..2 are never written.
// TESTING
//  T1 reset, 1 tick, waitrequest=0 -> writes (3,92)(4,01)(5,2D)(6,01) in T+2..T+5 (x=402, y=301);
//     busy high for 5 cycles.
//  T2 as T1, waitrequest=1 for 3 cycles on first write -> addr 3/data 92 held stable; sequence ends at T+9.
//  T3 INIT_X=608, tick -> x=609 (clamp), dir flips; next tick -> x=607; addr 3/4 data 61/02 then 5F/02.
//  T4 second tick 2 cycles after first -> missed_frames=1, write sequence unchanged;
//     300 such ticks -> missed_frames=255.
//  T5 reset asserted during WR_YL -> avm_write=0 same cycle; next tick writes x=402, y=301 again.
//  T6 (BALL_BOUNCE_COLOR_EN) INIT_Y=448, tick -> y=449 bounce;
//     7 writes ending (0,FF)(1,00)(2,00); next tick gives 4 writes.

Source files
------------

// File: rtl/ball_motion_master.sv
// Avalon-MM write initiator that steps and bounces the vga_ball centre once per frame.
// Define BALL_BOUNCE_COLOR_EN to also rewrite the ball colour on every bounce frame.
module ball_motion_master #(
   parameter int unsigned X_MIN  = 0,
   parameter int unsigned X_MAX  = 639,
   parameter int unsigned Y_MIN  = 0,
   parameter int unsigned Y_MAX  = 479,
   parameter int unsigned RADIUS = 30,
   parameter int unsigned VX     = 2,
   parameter int unsigned VY     = 1,
   parameter logic [10:0] INIT_X = 11'd400,
   parameter logic [9:0]  INIT_Y = 10'd300
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       enable,
   output logic       avm_chipselect,
   output logic       avm_write,
   output logic [2:0] avm_address,
   output logic [7:0] avm_writedata,
   input  logic       avm_waitrequest,
   output logic       busy,
   output logic [7:0] missed_frames
);

   localparam logic [11:0] XLo   = 12'(X_MIN + RADIUS);
   localparam logic [11:0] XHi   = 12'(X_MAX - RADIUS);
   localparam logic [11:0] YLo   = 12'(Y_MIN + RADIUS);
   localparam logic [11:0] YHi   = 12'(Y_MAX - RADIUS);
   localparam logic [11:0] StepX = 12'(VX);
   localparam logic [11:0] StepY = 12'(VY);

`ifdef BALL_BOUNCE_COLOR_EN
   typedef enum logic [3:0] {
      StIdle, StUpdate, StWrXl, StWrXh, StWrYl, StWrYh, StWrR, StWrG, StWrB
   } state_e;
`else
   typedef enum logic [3:0] {
      StIdle, StUpdate, StWrXl, StWrXh, StWrYl, StWrYh
   } state_e;
`endif

   state_e      state_q, state_d;
   logic [10:0] x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic        dir_x_q, dir_x_d;  // 1 = moving towards larger coordinates
   logic        dir_y_q, dir_y_d;
   logic [7:0]  missed_q, missed_d;
`ifdef BALL_BOUNCE_COLOR_EN
   logic        bounce_q, bounce_d;
   logic [2:0]  color_q, color_d;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         x_q      <= INIT_X;
         y_q      <= INIT_Y;
         dir_x_q  <= 1'b1;
         dir_y_q  <= 1'b1;
         missed_q <= 8'd0;
`ifdef BALL_BOUNCE_COLOR_EN
         bounce_q <= 1'b0;
         color_q  <= 3'd0;
`endif
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         dir_x_q  <= dir_x_d;
         dir_y_q  <= dir_y_d;
         missed_q <= missed_d;
`ifdef BALL_BOUNCE_COLOR_EN
         bounce_q <= bounce_d;
         color_q  <= color_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (frame_tick && enable) state_d = StUpdate;
         StUpdate: state_d = StWrXl;
         StWrXl:   if (!avm_waitrequest) state_d = StWrXh;
         StWrXh:   if (!avm_waitrequest) state_d = StWrYl;
         StWrYl:   if (!avm_waitrequest) state_d = StWrYh;
`ifdef BALL_BOUNCE_COLOR_EN
         StWrYh:   if (!avm_waitrequest) state_d = bounce_q ? StWrR : StIdle;
         StWrR:    if (!avm_waitrequest) state_d = StWrG;
         StWrG:    if (!avm_waitrequest) state_d = StWrB;
         StWrB:    if (!avm_waitrequest) state_d = StIdle;
`else
         StWrYh:   if (!avm_waitrequest) state_d = StIdle;
`endif
         default:  state_d = StIdle;
      endcase
   end

   // Position step: comparisons are 12 bits wide so neither edge test can wrap.
   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      dir_x_d  = dir_x_q;
      dir_y_d  = dir_y_q;
      missed_d = missed_q;
`ifdef BALL_BOUNCE_COLOR_EN
      bounce_d = bounce_q;
      color_d  = color_q;
`endif
      if (state_q == StUpdate) begin
         if (dir_x_q) begin
            if ({1'b0, x_q} + StepX >= XHi) begin
               x_d     = XHi[10:0];
               dir_x_d = 1'b0;
            end else begin
               x_d = x_q + StepX[10:0];
            end
         end else if ({1'b0, x_q} < XLo + StepX) begin
            x_d     = XLo[10:0];
            dir_x_d = 1'b1;
         end else begin
            x_d = x_q - StepX[10:0];
         end
         if (dir_y_q) begin
            if ({2'b0, y_q} + StepY >= YHi) begin
               y_d     = YHi[9:0];
               dir_y_d = 1'b0;
            end else begin
               y_d = y_q + StepY[9:0];
            end
         end else if ({2'b0, y_q} < YLo + StepY) begin
            y_d     = YLo[9:0];
            dir_y_d = 1'b1;
         end else begin
            y_d = y_q - StepY[9:0];
         end
`ifdef BALL_BOUNCE_COLOR_EN
         bounce_d = (dir_x_d != dir_x_q) || (dir_y_d != dir_y_q);
         if (bounce_d) color_d = color_q + 3'd1;
`endif
      end
      // Includes the final write cycle, so a tick coinciding with the return to idle is lost.
      if (state_q != StIdle && frame_tick && enable && missed_q != 8'hFF) begin
         missed_d = missed_q + 8'd1;
      end
   end

   always_comb begin
      avm_write     = 1'b0;
      avm_address   = 3'd0;
      avm_writedata = 8'h00;
      unique case (state_q)
         StWrXl: begin
            avm_write     = 1'b1;
            avm_address   = 3'd3;
            avm_writedata = x_q[7:0];
         end
         StWrXh: begin
            avm_write     = 1'b1;
            avm_address   = 3'd4;
            avm_writedata = {5'b0, x_q[10:8]};
         end
         StWrYl: begin
            avm_write     = 1'b1;
            avm_address   = 3'd5;
            avm_writedata = y_q[7:0];
         end
         StWrYh: begin
            avm_write     = 1'b1;
            avm_address   = 3'd6;
            avm_writedata = {6'b0, y_q[9:8]};
         end
`ifdef BALL_BOUNCE_COLOR_EN
         StWrR: begin
            avm_write     = 1'b1;
            avm_address   = 3'd0;
            avm_writedata = {8{color_q[0]}};
         end
         StWrG: begin
            avm_write     = 1'b1;
            avm_address   = 3'd1;
            avm_writedata = {8{color_q[1]}};
         end
         StWrB: begin
            avm_write     = 1'b1;
            avm_address   = 3'd2;
            avm_writedata = {8{color_q[2]}};
         end
`endif
         default: begin
         end
      endcase
      avm_chipselect = avm_write;
      busy           = (state_q != StIdle);
      missed_frames  = missed_q;
   end

endmodule

// File: tb/tb_ball_motion_master.sv
// Bench for ball_motion_master: default-position instance (a) and an edge-start instance (b).
// Expected colour writes follow BALL_BOUNCE_COLOR_EN when it is defined.
module tb_ball_motion_master;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       enable = 1'b0;
   logic       avm_waitrequest = 1'b0;
   logic       cs_a, wr_a, busy_a, cs_b, wr_b, busy_b;
   logic [2:0] addr_a, addr_b;
   logic [7:0] data_a, data_b, missed_a, missed_b;
   logic [10:0] log_a[$];
   logic [10:0] log_b[$];
   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      bit         rst;
      bit         en;
      bit         tick;
      bit         wt;
      bit         wr;
      logic [2:0] addr;
      logic [7:0] data;
      bit         busy;
   } vec_t;

   always #10 clk = ~clk;

   ball_motion_master dut_a (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
      .avm_chipselect(cs_a), .avm_write(wr_a), .avm_address(addr_a), .avm_writedata(data_a),
      .avm_waitrequest(avm_waitrequest), .busy(busy_a), .missed_frames(missed_a)
   );

   ball_motion_master #(.INIT_X(11'd608), .INIT_Y(10'd448)) dut_b (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
      .avm_chipselect(cs_b), .avm_write(wr_b), .avm_address(addr_b), .avm_writedata(data_b),
      .avm_waitrequest(avm_waitrequest), .busy(busy_b), .missed_frames(missed_b)
   );

   // Accepted writes, logged as {addr, data}.
   always @(negedge clk) begin
      if (!reset && wr_a && !avm_waitrequest) log_a.push_back({addr_a, data_a});
      if (!reset && wr_b && !avm_waitrequest) log_b.push_back({addr_b, data_b});
   end

   function automatic vec_t mk(bit rst, bit en, bit tick, bit wt, bit wr, logic [2:0] addr,
                               logic [7:0] data, bit busy);
      vec_t v;
      v.rst = rst; v.en = en; v.tick = tick; v.wt = wt;
      v.wr = wr; v.addr = addr; v.data = data; v.busy = busy;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_log(input string name, input logic [10:0] got[$],
                            input logic [10:0] exp[$]);
      check({name, "_count"}, 32'(got.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size(); i++) begin
         check($sformatf("%s_wr%0d", name, i), 32'(i < got.size() ? got[i] : 11'h7FF),
               32'(exp[i]));
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1 frame_tick = 1'b1;
      @(posedge clk);
      #1 frame_tick = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (!busy_a && !busy_b) done = 1'b1;
      end
      check(name, 32'(done), 32'd1);
   endtask

   initial begin
      vec_t vec[19];
      logic [10:0] exp[$];
      // Disabled tick, then a zero-wait frame, then a frame with three stall cycles.
      vec[0]  = mk(1, 0, 1, 0, 0, 3'd0, 8'h00, 0);
      vec[1]  = mk(0, 0, 0, 0, 0, 3'd0, 8'h00, 0);
      vec[2]  = mk(0, 1, 1, 0, 0, 3'd0, 8'h00, 0);
      vec[3]  = mk(0, 1, 0, 0, 0, 3'd0, 8'h00, 1);
      vec[4]  = mk(0, 1, 0, 0, 1, 3'd3, 8'h92, 1);
      vec[5]  = mk(0, 1, 0, 0, 1, 3'd4, 8'h01, 1);
      vec[6]  = mk(0, 1, 0, 0, 1, 3'd5, 8'h2D, 1);
      vec[7]  = mk(0, 1, 0, 0, 1, 3'd6, 8'h01, 1);
      vec[8]  = mk(0, 1, 0, 0, 0, 3'd0, 8'h00, 0);
      vec[9]  = mk(1, 1, 1, 0, 0, 3'd0, 8'h00, 0);
      vec[10] = mk(0, 1, 0, 0, 0, 3'd0, 8'h00, 1);
      vec[11] = mk(0, 1, 0, 1, 1, 3'd3, 8'h92, 1);
      vec[12] = mk(0, 1, 0, 1, 1, 3'd3, 8'h92, 1);
      vec[13] = mk(0, 1, 0, 1, 1, 3'd3, 8'h92, 1);
      vec[14] = mk(0, 1, 0, 0, 1, 3'd3, 8'h92, 1);
      vec[15] = mk(0, 1, 0, 0, 1, 3'd4, 8'h01, 1);
      vec[16] = mk(0, 1, 0, 0, 1, 3'd5, 8'h2D, 1);
      vec[17] = mk(0, 1, 0, 0, 1, 3'd6, 8'h01, 1);
      vec[18] = mk(0, 1, 0, 0, 0, 3'd0, 8'h00, 0);

      @(negedge clk);
      check("rst_write", 32'(wr_a), 32'd0);
      check("rst_cs", 32'(cs_a), 32'd0);
      check("rst_addr", 32'(addr_a), 32'd0);
      check("rst_data", 32'(data_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_missed", 32'(missed_a), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 19; i++) begin
         if (vec[i].rst) do_reset();
         @(posedge clk);
         #1;
         enable = vec[i].en;
         frame_tick = vec[i].tick;
         avm_waitrequest = vec[i].wt;
         @(negedge clk);
         check($sformatf("vec%0d_write", i), 32'(wr_a), 32'(vec[i].wr));
         check($sformatf("vec%0d_cs", i), 32'(cs_a), 32'(vec[i].wr));
         check($sformatf("vec%0d_busy", i), 32'(busy_a), 32'(vec[i].busy));
         if (vec[i].wr) begin
            check($sformatf("vec%0d_addr", i), 32'(addr_a), 32'(vec[i].addr));
            check($sformatf("vec%0d_data", i), 32'(data_a), 32'(vec[i].data));
         end
      end
      check("vec_missed", 32'(missed_a), 32'd0);

      // Edge clamp on instance b: x 608->609 and y 448->449 bounce, then step back.
      do_reset();
      log_a.delete();
      log_b.delete();
      tick();
      wait_idle("edge1_idle");
      exp = '{11'h392, 11'h401, 11'h52D, 11'h601};
      check_log("edge1_a", log_a, exp);
`ifdef BALL_BOUNCE_COLOR_EN
      exp = '{11'h361, 11'h402, 11'h5C1, 11'h601, 11'h0FF, 11'h100, 11'h200};
`else
      exp = '{11'h361, 11'h402, 11'h5C1, 11'h601};
`endif
      check_log("edge1_b", log_b, exp);
      log_b.delete();
      tick();
      wait_idle("edge2_idle");
      exp = '{11'h35F, 11'h402, 11'h5C0, 11'h601};
      check_log("edge2_b", log_b, exp);

      // Second tick two cycles into a frame is dropped and counted.
      do_reset();
      log_a.delete();
      tick();
      @(posedge clk);
      #1 frame_tick = 1'b1;
      @(posedge clk);
      #1 frame_tick = 1'b0;
      wait_idle("drop_idle");
      check("drop_missed", 32'(missed_a), 32'd1);
      exp = '{11'h392, 11'h401, 11'h52D, 11'h601};
      check_log("drop_a", log_a, exp);

      // Tick in the last write cycle is missed; the following one is accepted.
      do_reset();
      tick();
      repeat (4) @(posedge clk);
      #1 frame_tick = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 frame_tick = 1'b0;
      @(negedge clk);
      check("last_cycle_busy", 32'(busy_a), 32'd1);
      check("last_cycle_missed", 32'(missed_a), 32'd1);
      wait_idle("last_cycle_idle");

      // Saturation of the missed-frame counter.
      do_reset();
      @(posedge clk);
      #1 frame_tick = 1'b1;
      repeat (400) @(posedge clk);
      #1 frame_tick = 1'b0;
      wait_idle("sat_idle");
      check("sat_missed_a", 32'(missed_a), 32'd255);
      check("sat_missed_b", 32'(missed_b), 32'd255);

      // Reset during the Y-low write drops the strobe at once and restores the start position.
      do_reset();
      tick();
      repeat (3) @(posedge clk);
      #1;
      check("mid_addr", 32'(addr_a), 32'd5);
      check("mid_write", 32'(wr_a), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_write", 32'(wr_a), 32'd0);
      check("mid_rst_cs", 32'(cs_a), 32'd0);
      check("mid_rst_busy", 32'(busy_a), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      log_a.delete();
      tick();
      wait_idle("mid_idle");
      exp = '{11'h392, 11'h401, 11'h52D, 11'h601};
      check_log("mid_a", log_a, exp);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
